// File: rtl/muldiv_riscv.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring
// divide, one bit per cycle, with a valid/ready request handshake.
module muldiv_riscv #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic {IDLE, CALC} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      op_q;
  logic            neg_q;
  logic [XLEN-1:0] acc_q, lo_q, mcand_q;

  // Operand decode at accept time
  logic            a_signed, b_signed, a_neg, b_neg, is_div, div_zero, div_ovf, neg_d;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  assign a_signed = !(op_i[0] && (op_i[1] || op_i[2]));
  assign b_signed = a_signed && (op_i != 3'b010);
  assign a_neg    = a_signed && a_i[XLEN-1];
  assign b_neg    = b_signed && b_i[XLEN-1];
  assign a_mag    = a_neg ? -a_i : a_i;
  assign b_mag    = b_neg ? -b_i : b_i;
  assign is_div   = op_i[2];
  assign div_zero = is_div && (b_i == '0);
  assign div_ovf  = is_div && !op_i[0] && (a_i == MIN) && (b_i == '1);
  // Remainder follows the dividend sign; everything else uses the XOR of signs
  assign neg_d    = (is_div && op_i[1]) ? a_neg : (a_neg ^ b_neg);

  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = op_i[1] ? a_i : '1;
    else
      special_res = op_i[1] ? '0 : a_i;
  end

  // One datapath iteration: {acc_q, lo_q} is the product or remainder:quotient pair
  logic [XLEN:0]     mul_sum, div_sh;
  logic [XLEN-1:0]   div_sub, acc_d, lo_d;
  logic              div_ge;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, final_res;

  assign mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
  assign div_sh  = {acc_q, lo_q[XLEN-1]};
  assign div_ge  = div_sh >= {1'b0, mcand_q};
  assign div_sub = div_sh[XLEN-1:0] - mcand_q;

  always_comb begin
    acc_d = mul_sum[XLEN:1];
    lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
    if (op_q[2]) begin
      acc_d = div_ge ? div_sub : div_sh[XLEN-1:0];
      lo_d  = {lo_q[XLEN-2:0], div_ge};
    end
  end

  assign prod   = {acc_d, lo_d};
  assign prod_s = neg_q ? -prod : prod;
  assign quo_s  = neg_q ? -lo_d : lo_d;
  assign rem_s  = neg_q ? -acc_d : acc_d;

  always_comb begin
    final_res = prod_s[XLEN-1:0];
    case (op_q)
      3'b001, 3'b010, 3'b011: final_res = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res = quo_s;
      3'b110, 3'b111:         final_res = rem_s;
      default:                final_res = prod_s[XLEN-1:0];
    endcase
  end

  assign ready_o = (state_q == IDLE);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      valid_o  <= 1'b0;
      result_o <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
    end else begin
      valid_o <= 1'b0;
      if (flush_i) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (valid_i) begin
              op_q  <= op_i;
              neg_q <= neg_d;
              cnt_q <= '0;
              if (div_zero || div_ovf) begin
                result_o <= special_res;
                valid_o  <= 1'b1;
              end else begin
                state_q <= CALC;
                acc_q   <= '0;
                lo_q    <= a_mag;
                mcand_q <= b_mag;
              end
            end
          end
          CALC: begin
            acc_q <= acc_d;
            lo_q  <= lo_d;
            if (cnt_q == LAST) begin
              result_o <= final_res;
              valid_o  <= 1'b1;
              state_q  <= IDLE;
              cnt_q    <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule
